// File: rtl/frame_v_average_if.sv
// frame_v_average_if: pixel-in and average-out req/ack handshakes.
interface frame_v_average_if;
  logic [7:0] pixel_v_in;
  logic       recv_req;
  logic       frame_end;
  logic       recv_ack;
  logic [7:0] avg_v;
  logic       send_req;
  logic       send_ack;
  modport master (output pixel_v_in, recv_req, frame_end, send_ack, input recv_ack, avg_v, send_req);
  modport slave  (input pixel_v_in, recv_req, frame_end, send_ack, output recv_ack, avg_v, send_req);
endinterface

// File: rtl/frame_v_average.sv
// frame_v_average: accumulates a frame of pixel V values, then divides sum by count with round-half-up.
module frame_v_average #(
  parameter int PIX_CNT_W = 20,
  parameter int ACC_W     = PIX_CNT_W + 8
) (
  input  logic              clk,
  input  logic              reset,
  frame_v_average_if.slave  bus
);
  localparam int IT_W = $clog2(ACC_W + 1);
  typedef enum logic [1:0] {ACCUM, DIVIDE, HOLD} state_t;
  state_t               r_state, w_state_nxt;
  logic [ACC_W-1:0]     r_sum, r_quo, w_sum_nxt, w_trial, w_quo_nxt;
  logic [ACC_W-2:0]     r_rem, w_rem_nxt;
  logic [PIX_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [IT_W-1:0]      r_iter;
  logic [7:0]           r_avg;
  logic                 r_send_req, w_accept, w_last, w_ge, w_done;
  assign bus.recv_ack = r_state == ACCUM;
  assign bus.avg_v    = r_avg;
  assign bus.send_req = r_send_req;
  assign w_accept     = bus.recv_req & bus.recv_ack;
  assign w_sum_nxt    = r_sum + ACC_W'(bus.pixel_v_in);
  assign w_cnt_nxt    = r_cnt + PIX_CNT_W'(1);
  // a full counter forces the frame to close even without frame_end
  assign w_last       = bus.frame_end | (&w_cnt_nxt);
  // restoring division: remainder stays below count, so its top bit is never needed
  assign w_trial      = {r_rem, r_quo[ACC_W-1]};
  assign w_ge         = w_trial >= ACC_W'(r_cnt);
  assign w_rem_nxt    = w_ge ? (ACC_W-1)'(w_trial - ACC_W'(r_cnt)) : w_trial[ACC_W-2:0];
  assign w_quo_nxt    = {r_quo[ACC_W-2:0], w_ge};
  assign w_done       = r_iter == IT_W'(ACC_W - 1);
  always_comb begin
    w_state_nxt = r_state;
    if (w_accept && w_last) w_state_nxt = DIVIDE;
    if (r_state == DIVIDE && w_done) w_state_nxt = HOLD;
    if (r_state == HOLD && bus.send_ack) w_state_nxt = ACCUM;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= ACCUM;
    else r_state <= w_state_nxt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_sum      <= '0;
      r_cnt      <= '0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_iter     <= '0;
      r_avg      <= '0;
      r_send_req <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sum  <= w_sum_nxt;
        r_cnt  <= w_cnt_nxt;
        r_quo  <= w_sum_nxt + ACC_W'(w_cnt_nxt >> 1);
        r_rem  <= '0;
        r_iter <= '0;
      end
      if (r_state == DIVIDE) begin
        r_rem  <= w_rem_nxt;
        r_quo  <= w_quo_nxt;
        r_iter <= r_iter + IT_W'(1);
        if (w_done) begin
          r_avg      <= |w_quo_nxt[ACC_W-1:8] ? 8'hFF : w_quo_nxt[7:0];
          r_send_req <= 1'b1;
        end
      end
      if (r_state == HOLD && bus.send_ack) begin
        r_send_req <= 1'b0;
        r_sum      <= '0;
        r_cnt      <= '0;
      end
    end
endmodule

// File: tb/tb_frame_v_average.sv
// tb_frame_v_average: randomized frames checked against a queue-based rounding-average model.
module tb_frame_v_average;
  localparam int ACC  = 28;
  localparam int ACC4 = 12;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;
  int q_pix[$];
  frame_v_average_if u();
  frame_v_average_if u4();
  frame_v_average dut (.clk(clk), .reset(reset), .bus(u));
  frame_v_average #(.PIX_CNT_W(4)) dut4 (.clk(clk), .reset(reset), .bus(u4));
  always #5 clk = ~clk;
  function automatic int ref_avg();
    longint s = 0;
    longint n = q_pix.size();
    foreach (q_pix[i]) s += q_pix[i];
    s = (s + n / 2) / n;
    return (s > 255) ? 255 : int'(s);
  endfunction
  task automatic push(input int v, input bit fe);
    int t = 0;
    @(negedge clk);
    u.pixel_v_in = 8'(v);
    u.recv_req = 1'b1;
    u.frame_end = fe;
    while (u.recv_ack !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 100) begin
      failures++;
      $display("FAIL push_timeout recv_ack=%b required=1", u.recv_ack);
    end
    @(posedge clk);
    #1;
    u.recv_req = 1'b0;
    u.frame_end = 1'b0;
    q_pix.push_back(v);
  endtask
  task automatic check_result(input string nm);
    int lat = 0;
    int exp_v = ref_avg();
    q_pix.delete();
    while (u.send_req !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat != ACC) begin
      failures++;
      $display("FAIL %s_latency got=%0d required=%0d", nm, lat, ACC);
    end
    checks++;
    if (u.avg_v !== 8'(exp_v)) begin
      failures++;
      $display("FAIL %s_avg got=%0d required=%0d", nm, u.avg_v, exp_v);
    end
  endtask
  task automatic do_ack(input string nm);
    @(negedge clk);
    u.send_ack = 1'b1;
    @(posedge clk);
    #1;
    u.send_ack = 1'b0;
    checks++;
    if (u.send_req !== 1'b0 || u.recv_ack !== 1'b1) begin
      failures++;
      $display("FAIL %s_ack send_req=%b recv_ack=%b required 0/1", nm, u.send_req, u.recv_ack);
    end
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (u.send_req !== 1'b0 || u.avg_v !== 8'd0) begin
      failures++;
      $display("FAIL reset_outputs send_req=%b avg_v=%0d required 0/0", u.send_req, u.avg_v);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (u.recv_ack !== 1'b1 || u4.recv_ack !== 1'b1) begin
      failures++;
      $display("FAIL reset_recv_ack got=%b/%b required=1/1", u.recv_ack, u4.recv_ack);
    end
  endtask
  task automatic test_basic();
    push(10, 0); push(20, 0); push(30, 0); push(40, 1);
    checks++;
    if (u.recv_ack !== 1'b0) begin
      failures++;
      $display("FAIL basic_divide_recv_ack got=%b required=0", u.recv_ack);
    end
    check_result("basic");
    do_ack("basic");
  endtask
  task automatic test_rounding();
    push(255, 1);
    check_result("single255");
    do_ack("single255");
    push(1, 0); push(2, 1);
    check_result("round_half");
    do_ack("round_half");
    push(0, 0); push(1, 0); push(1, 1);
    check_result("round_down");
    do_ack("round_down");
  endtask
  task automatic test_backpressure();
    int bad = 0;
    push(60, 0); push(61, 1);
    check_result("bp_frame");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      u.pixel_v_in = 8'($urandom_range(0, 255));
      u.recv_req = 1'b1;
      u.frame_end = 1'($urandom_range(0, 1));
      #1;
      if (u.recv_ack !== 1'b0 || u.send_req !== 1'b1 || u.avg_v !== 8'd61) bad++;
    end
    u.recv_req = 1'b0;
    u.frame_end = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL backpressure_hold bad_cycles=%0d required=0", bad);
    end
    do_ack("bp_frame");
    push(100, 0); push(100, 1);
    check_result("bp_next");
    do_ack("bp_next");
  endtask
  task automatic test_gaps();
    for (int i = 0; i < 8; i++) begin
      int gaps = (i == 3) ? 1 : $urandom_range(0, 3);
      for (int g = 0; g < gaps; g++) begin
        @(negedge clk);
        u.frame_end = (i == 3) ? 1'b1 : 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        u.frame_end = 1'b0;
        checks++;
        if (u.recv_ack !== 1'b1) begin
          failures++;
          $display("FAIL gap_frame_end_ignored recv_ack=%b required=1", u.recv_ack);
        end
      end
      push(50, i == 7);
    end
    check_result("gaps");
    do_ack("gaps");
  endtask
  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      int len = $urandom_range(1, 24);
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        push($urandom_range(0, 255), i == len - 1);
      end
      check_result("random");
      do_ack("random");
    end
  endtask
  task automatic test_forced();
    int bad = 0;
    int lat = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      u4.pixel_v_in = 8'd100;
      u4.recv_req = 1'b1;
      u4.frame_end = 1'b0;
      if (u4.recv_ack !== 1'b1) bad++;
      @(posedge clk);
      #1;
    end
    u4.recv_req = 1'b0;
    checks++;
    if (bad != 0 || u4.recv_ack !== 1'b0) begin
      failures++;
      $display("FAIL forced_entry refused=%0d recv_ack=%b required 0/0", bad, u4.recv_ack);
    end
    while (u4.send_req !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat != ACC4) begin
      failures++;
      $display("FAIL forced_latency got=%0d required=%0d", lat, ACC4);
    end
    checks++;
    if (u4.avg_v !== 8'd100) begin
      failures++;
      $display("FAIL forced_avg got=%0d required=100", u4.avg_v);
    end
    @(negedge clk);
    u4.send_ack = 1'b1;
    @(posedge clk);
    #1;
    u4.send_ack = 1'b0;
    checks++;
    if (u4.send_req !== 1'b0 || u4.recv_ack !== 1'b1) begin
      failures++;
      $display("FAIL forced_ack send_req=%b recv_ack=%b required 0/1", u4.send_req, u4.recv_ack);
    end
  endtask
  task automatic abort_check(input string nm);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (u.send_req !== 1'b0 || u.avg_v !== 8'd0) begin
      failures++;
      $display("FAIL %s_reset send_req=%b avg_v=%0d required 0/0", nm, u.send_req, u.avg_v);
    end
    q_pix.delete();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (u.recv_ack !== 1'b1 || u.send_req !== 1'b0) begin
      failures++;
      $display("FAIL %s_release recv_ack=%b send_req=%b required 1/0", nm, u.recv_ack, u.send_req);
    end
    push(8, 0); push(8, 1);
    check_result({nm, "_next"});
    do_ack({nm, "_next"});
  endtask
  task automatic test_abort();
    push(7, 1);
    check_result("pre_abort");
    do_ack("pre_abort");
    push(200, 0); push(200, 1);
    repeat (10) @(posedge clk);
    abort_check("abort_divide");
    push(90, 1);
    check_result("pre_hold");
    repeat (3) @(posedge clk);
    abort_check("abort_hold");
  endtask
  initial begin
    u.pixel_v_in = '0; u.recv_req = 1'b0; u.frame_end = 1'b0; u.send_ack = 1'b0;
    u4.pixel_v_in = '0; u4.recv_req = 1'b0; u4.frame_end = 1'b0; u4.send_ack = 1'b0;
    test_reset();
    test_basic();
    test_rounding();
    test_backpressure();
    test_gaps();
    test_random();
    test_forced();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
